// File: rtl/multi_cycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multi_cycle_control
// Purpose  : Moore sequencing FSM for the multi-cycle MIPS datapath.
// Revision : 1.0
// ============================================================================
module multi_cycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCondEq,
  output logic             PCWriteCondNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [5:0] c_opRtype = 6'b000000;
  localparam logic [5:0] c_opJ     = 6'b000010;
  localparam logic [5:0] c_opBeq   = 6'b000100;
  localparam logic [5:0] c_opBne   = 6'b000101;
  localparam logic [5:0] c_opAddi  = 6'b001000;
  localparam logic [5:0] c_opAndi  = 6'b001100;
  localparam logic [5:0] c_opLw    = 6'b100011;
  localparam logic [5:0] c_opSw    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IMM_EXEC = 4'd10,
    S_IMM_WB   = 4'd11,
    S_HALT     = 4'd15
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  always_comb begin
    w_nextState = S_FETCH;
    case (r_state)
      S_FETCH:    w_nextState = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          c_opLw, c_opSw:     w_nextState = S_MEM_ADDR;
          c_opRtype:          w_nextState = S_EXEC;
          c_opBeq, c_opBne:   w_nextState = S_BRANCH;
          c_opJ:              w_nextState = S_JUMP;
          c_opAddi, c_opAndi: w_nextState = S_IMM_EXEC;
          default:            w_nextState = S_HALT;
        endcase
      end
      S_MEM_ADDR: w_nextState = (opcode == c_opSw) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_nextState = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_nextState = S_FETCH;
      S_MEM_WR:   w_nextState = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     w_nextState = S_R_WB;
      S_R_WB:     w_nextState = S_FETCH;
      S_BRANCH:   w_nextState = S_FETCH;
      S_JUMP:     w_nextState = S_FETCH;
      S_IMM_EXEC: w_nextState = S_IMM_WB;
      S_IMM_WB:   w_nextState = S_FETCH;
      S_HALT:     w_nextState = S_HALT;
      default:    w_nextState = S_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB: w_retire = 1'b1;
      S_MEM_WR:                                     w_retire = mem_ready;
      default:                                      w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_retire) begin
        r_retired <= r_retired + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCondEq = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCSource      = 2'b01;
        PCWriteCondEq = (opcode == c_opBeq);
        PCWriteCondNe = (opcode == c_opBne);
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IMM_EXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = (opcode == c_opAndi) ? 2'b11 : 2'b00;
      end
      S_IMM_WB:   RegWrite = 1'b1;
      default: ;
    endcase
    // Reset kills every side-effecting strobe before the edge takes effect.
    if (reset) begin
      PCWrite       = 1'b0;
      PCWriteCondEq = 1'b0;
      PCWriteCondNe = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
    end
  end

  assign state   = r_state;
  assign halted  = (r_state == S_HALT);
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Moore-style sequencing FSM for the multi-cycle variant of the MIPS datapath: one shared memory, one ALU, and IR/MDR/A/B/ALUOut holding registers.
- Each instruction is split into 3–5 states. The block drives every datapath strobe and mux select from the current state and the IR opcode.
- It stalls on memory through a `mem_ready` handshake, halts on illegal opcodes, and counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]; stable from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCondEq  out  1  PC load if ALU zero (beq)
- PCWriteCondNe  out  1  PC load if ALU not zero (bne)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR load
- MemtoReg  out  1  register write data select: 1 = MDR, 0 = ALUOut
- RegDst  out  1  destination register select: 1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU input A select: 0 = PC, 1 = A
- ALUSrcB  out  2  ALU input B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  2  00 = add, 01 = sub, 10 = funct, 11 = and
- PCSource  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state, for debug
- halted  out  1  high while in HALT
- retired  out  CNT_W  count of instructions completed

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, R_WB=7, BRANCH=8, JUMP=9, IMM_EXEC=10, IMM_WB=11, HALT=15. Codes 12–14 are unreachable; if entered, go to FETCH.
- Reset (sampled at the edge): next state = FETCH, retired = 0, halted = 0. While reset is high, all strobes are forced to 0: PCWrite, PCWriteCondEq, PCWriteCondNe, MemRead, MemWrite, IRWrite, RegWrite. Reset mid-instruction abandons the instruction and does not count it.
- Outputs are combinational from state (and opcode/mem_ready where noted). Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready.
  - Transition: DECODE if mem_ready, else stay.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by opcode: 100011 (lw) / 101011 (sw) → MEM_ADDR; 000000 → EXEC; 000100 (beq) / 000101 (bne) → BRANCH; 000010 → JUMP; 001000 (addi) / 001100 (andi) → IMM_EXEC; any other → HALT.
- MEM_ADDR:
  - Outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Transition: lw → MEM_RD; sw → MEM_WR.
- MEM_RD:
  - Outputs: MemRead=1, IorD=1.
  - Transition: MEM_WB if mem_ready, else stay.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Next FETCH.
- MEM_WR:
  - Outputs: MemWrite=1, IorD=1. MemWrite stays asserted while waiting.
  - Transition: FETCH if mem_ready, else stay.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1. Next FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01. PCWriteCondEq=(opcode==000100); PCWriteCondNe=(opcode==000101).
  - Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- IMM_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for addi, 11 for andi. Next IMM_WB.
- IMM_WB: RegDst=0, MemtoReg=0, RegWrite=1. Next FETCH.
- HALT: all strobes 0, halted=1. Stays until reset.
- Retired counter:
  - Increments by 1 on each edge where state leaves MEM_WB, R_WB, BRANCH, JUMP or IMM_WB, or leaves MEM_WR with mem_ready=1.
  - Wraps modulo 2^CNT_W.
  - Never increments on the HALT path; a taken or untaken branch both count.
- Cycle counts with mem_ready constantly 1: lw 5, sw 4, R-type 4, addi/andi 4, beq/bne 3, j 3.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- `mem_ready` is ignored in all other states.

Test Plan:
- Reset, then lw (opcode 100011), mem_ready=1 → states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; retired=1 after 5 cycles.
- sw with mem_ready low for 2 cycles in MEM_WR → states 0,1,2,5,5,5,0; MemWrite=1 for all three MEM_WR cycles; retired=1.
- beq then bne → in BRANCH, PCWriteCondEq=1/PCWriteCondNe=0 for beq and the reverse for bne; PCSource=01, ALUOp=01; 3 cycles each; retired=2.
- Mixed sequence: j, R-type, addi, andi → JUMP asserts PCWrite with PCSource=10; EXEC has ALUOp=10; IMM_EXEC has ALUOp=00 then 11; retired=4 after 15 cycles.
- Illegal opcode 111111 → DECODE goes to HALT; halted=1 and all strobes 0 for 20 cycles; retired unchanged.
- Reset asserted in MEM_RD while mem_ready=0 → strobes 0 during reset; next state FETCH, retired=0, halted=0.
